// File: rtl/frame_ram_arbiter_if.sv
// Bus bundle between the VGA reader, the coprocessor ports and the frame RAM macro.
// The arbiter takes the slave modport; clients and the RAM model see the master side.
interface frame_ram_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) ();
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    logic              cop_wr_en;
    logic [ADDR_W-1:0] cop_wr_addr;
    logic [DATA_W-1:0] cop_wr_data;
    logic              cop_wr_full;

    logic              cop_rd_req;
    logic [ADDR_W-1:0] cop_rd_addr;
    logic              cop_rd_gnt;
    logic              cop_rd_valid;
    logic [DATA_W-1:0] cop_rd_data;

    logic              idle;
    logic              overflow;
    logic              clear_flags;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  vga_req, vga_addr, cop_wr_en, cop_wr_addr, cop_wr_data,
               cop_rd_req, cop_rd_addr, clear_flags, ram_rdata,
        output vga_rvalid, vga_rdata, cop_wr_full, cop_rd_gnt, cop_rd_valid,
               cop_rd_data, idle, overflow, ram_addr, ram_wdata, ram_we
    );

    modport master (
        output vga_req, vga_addr, cop_wr_en, cop_wr_addr, cop_wr_data,
               cop_rd_req, cop_rd_addr, clear_flags, ram_rdata,
        input  vga_rvalid, vga_rdata, cop_wr_full, cop_rd_gnt, cop_rd_valid,
               cop_rd_data, idle, overflow, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/frame_ram_arbiter.sv
// Single-port frame RAM arbiter: VGA reads first, then buffered coprocessor writes, then coprocessor reads.
// Define FRAME_RAM_ARB_STALL_CNT_EN to add the stall_cnt port counting coprocessor cycles lost to VGA.
module frame_ram_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    frame_ram_arbiter_if.slave      bus
`ifdef FRAME_RAM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);
    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_VGA, SLOT_WR, SLOT_RD} slot_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_COP} owner_e;

    logic [ADDR_W+DATA_W-1:0] fifo_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic [CNT_W-1:0]         count_d;
    logic                     full_q;
    logic                     overflow_q;
    logic                     overflow_d;
    owner_e                   owner_q;
    logic [ADDR_W-1:0]        ram_addr_q;
    logic [DATA_W-1:0]        ram_wdata_q;

    slot_e                    slot_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     drop_s;
    logic [ADDR_W-1:0]        head_addr_s;
    logic [DATA_W-1:0]        head_data_s;
    logic [ADDR_W-1:0]        ram_addr_s;
    logic [DATA_W-1:0]        ram_wdata_s;
    logic                     ram_we_s;
    logic                     cop_rd_gnt_s;

    assign {head_addr_s, head_data_s} = fifo_q[rd_ptr_q];

    // Slot selection; a read also waits out a same-cycle push so it can never overtake that write.
    always_comb begin
        slot_s = SLOT_IDLE;
        if (rst) begin
            slot_s = SLOT_IDLE;
        end else if (bus.vga_req) begin
            slot_s = SLOT_VGA;
        end else if (count_q != CNT_W'(0)) begin
            slot_s = SLOT_WR;
        end else if (bus.cop_rd_req && !bus.cop_wr_en) begin
            slot_s = SLOT_RD;
        end else begin
            slot_s = SLOT_IDLE;
        end
    end

    // RAM-side drive for the chosen slot; address and write data hold when idle.
    always_comb begin
        ram_addr_s   = ram_addr_q;
        ram_wdata_s  = ram_wdata_q;
        ram_we_s     = 1'b0;
        cop_rd_gnt_s = 1'b0;
        pop_s        = 1'b0;
        case (slot_s)
            SLOT_VGA: begin
                ram_addr_s = bus.vga_addr;
            end
            SLOT_WR: begin
                ram_addr_s  = head_addr_s;
                ram_wdata_s = head_data_s;
                ram_we_s    = 1'b1;
                pop_s       = 1'b1;
            end
            SLOT_RD: begin
                ram_addr_s   = bus.cop_rd_addr;
                cop_rd_gnt_s = 1'b1;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    // FIFO occupancy and overflow next-state; a full FIFO still accepts when it pops the same cycle.
    always_comb begin
        push_s  = bus.cop_wr_en && (!full_q || pop_s);
        drop_s  = bus.cop_wr_en && full_q && !pop_s;
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (bus.clear_flags) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Write FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            fifo_q[wr_ptr_q] <= {bus.cop_wr_addr, bus.cop_wr_data};
        end
    end

    // Pointers, flags, read owner and held RAM address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= PTR_W'(0);
            rd_ptr_q    <= PTR_W'(0);
            count_q     <= CNT_W'(0);
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            owner_q     <= OWN_NONE;
            ram_addr_q  <= ADDR_W'(0);
            ram_wdata_q <= DATA_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q     <= count_d;
            full_q      <= (count_d == CNT_W'(WFIFO_DEPTH));
            overflow_q  <= overflow_d;
            ram_addr_q  <= ram_addr_s;
            ram_wdata_q <= ram_wdata_s;
            case (slot_s)
                SLOT_VGA: owner_q <= OWN_VGA;
                SLOT_RD:  owner_q <= OWN_COP;
                default:  owner_q <= OWN_NONE;
            endcase
        end
    end

    assign bus.ram_addr     = ram_addr_s;
    assign bus.ram_wdata    = ram_wdata_s;
    assign bus.ram_we       = ram_we_s;
    assign bus.cop_rd_gnt   = cop_rd_gnt_s;
    assign bus.vga_rvalid   = (owner_q == OWN_VGA);
    assign bus.vga_rdata    = bus.ram_rdata;
    assign bus.cop_rd_valid = (owner_q == OWN_COP);
    assign bus.cop_rd_data  = bus.ram_rdata;
    assign bus.cop_wr_full  = full_q;
    assign bus.overflow     = overflow_q;
    assign bus.idle         = (count_q == CNT_W'(0)) && (owner_q != OWN_COP) && !bus.cop_rd_req;

`ifdef FRAME_RAM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic        stall_inc_s;

    assign stall_inc_s = bus.vga_req && ((count_q != CNT_W'(0)) || bus.cop_rd_req);

    // Saturating count of cycles a pending coprocessor access lost the slot to VGA.
    always_ff @(posedge clk) begin
        if (rst || bus.clear_flags) begin
            stall_cnt_q <= 16'd0;
        end else if (stall_inc_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter with a registered 256-word RAM model.
// Unwritten model locations read back as their own low address byte.
module tb_frame_ram_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   wr_cnt;
    int   w0;

    logic [7:0]   mem_m [256];
    logic [255:0] written = '0;

    frame_ram_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus_if ();

`ifdef FRAME_RAM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
    frame_ram_arbiter #(.ADDR_W(19), .DATA_W(8), .WFIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus_if), .stall_cnt(stall_cnt));
`else
    frame_ram_arbiter #(.ADDR_W(19), .DATA_W(8), .WFIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus_if));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read-first, one cycle registered read latency; also counts writes.
    always @(posedge clk) begin
        if (bus_if.ram_we) begin
            mem_m[bus_if.ram_addr[7:0]]   <= bus_if.ram_wdata;
            written[bus_if.ram_addr[7:0]] <= 1'b1;
            wr_cnt                        <= wr_cnt + 1;
        end
        bus_if.ram_rdata <= written[bus_if.ram_addr[7:0]] ? mem_m[bus_if.ram_addr[7:0]]
                                                          : bus_if.ram_addr[7:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wr_cnt = 0;
        rst = 1'b1;
        bus_if.vga_req     = 1'b0;
        bus_if.vga_addr    = 19'd0;
        bus_if.cop_wr_en   = 1'b0;
        bus_if.cop_wr_addr = 19'd0;
        bus_if.cop_wr_data = 8'd0;
        bus_if.cop_rd_req  = 1'b0;
        bus_if.cop_rd_addr = 19'd0;
        bus_if.clear_flags = 1'b0;

        // Reset and idle
        repeat (3) cyc();
        rst = 1'b0;
        repeat (5) cyc();
        #3;
        check("rst_idle", bus_if.idle, 32'd1);
        check("rst_we", bus_if.ram_we, 32'd0);
        check("rst_addr", bus_if.ram_addr, 32'd0);
        check("rst_wdata", bus_if.ram_wdata, 32'd0);
        check("rst_vga_rvalid", bus_if.vga_rvalid, 32'd0);
        check("rst_cop_rvalid", bus_if.cop_rd_valid, 32'd0);
        check("rst_gnt", bus_if.cop_rd_gnt, 32'd0);
        check("rst_full", bus_if.cop_wr_full, 32'd0);
        check("rst_ovf", bus_if.overflow, 32'd0);
`ifdef FRAME_RAM_ARB_STALL_CNT_EN
        check("rst_stall", stall_cnt, 32'd0);
`endif
        cyc();

        // VGA stream 0..3 with a coprocessor read held pending
        bus_if.cop_rd_req  = 1'b1;
        bus_if.cop_rd_addr = 19'd5;
        for (int i = 0; i < 4; i++) begin
            bus_if.vga_req  = 1'b1;
            bus_if.vga_addr = 19'(i);
            #3;
            check("vga_gnt_blocked", bus_if.cop_rd_gnt, 32'd0);
            check("vga_ram_addr", bus_if.ram_addr, 32'(i));
            check("vga_we", bus_if.ram_we, 32'd0);
            if (i == 0) begin
                check("vga_rvalid_first", bus_if.vga_rvalid, 32'd0);
            end else begin
                check("vga_rvalid", bus_if.vga_rvalid, 32'd1);
                check("vga_rdata", bus_if.vga_rdata, 32'(i - 1));
            end
            cyc();
        end
        bus_if.vga_req = 1'b0;
        #3;
        check("vga_last_rvalid", bus_if.vga_rvalid, 32'd1);
        check("vga_last_rdata", bus_if.vga_rdata, 32'd3);
        check("rd_gnt_after_vga", bus_if.cop_rd_gnt, 32'd1);
        check("rd_addr_after_vga", bus_if.ram_addr, 32'd5);
`ifdef FRAME_RAM_ARB_STALL_CNT_EN
        check("stall_after_vga", stall_cnt, 32'd4);
`endif
        cyc();
        bus_if.cop_rd_req = 1'b0;
        #3;
        check("rd_valid", bus_if.cop_rd_valid, 32'd1);
        check("rd_data", bus_if.cop_rd_data, 32'd5);
        check("rd_vga_rvalid_off", bus_if.vga_rvalid, 32'd0);
        check("rd_idle_busy", bus_if.idle, 32'd0);
        cyc();
        #3;
        check("rd_idle_back", bus_if.idle, 32'd1);
        check("rd_valid_off", bus_if.cop_rd_valid, 32'd0);
        cyc();

        // Four writes drain in push order
        for (int k = 0; k < 4; k++) begin
            bus_if.cop_wr_en   = 1'b1;
            bus_if.cop_wr_addr = 19'(10 + k);
            bus_if.cop_wr_data = 8'(8'hA0 + k);
            #3;
            if (k == 0) begin
                check("wr_no_bypass", bus_if.ram_we, 32'd0);
            end else begin
                check("wr_we", bus_if.ram_we, 32'd1);
                check("wr_addr", bus_if.ram_addr, 32'(10 + k - 1));
                check("wr_data", bus_if.ram_wdata, 32'(8'hA0 + k - 1));
            end
            cyc();
        end
        bus_if.cop_wr_en = 1'b0;
        #3;
        check("wr_last_we", bus_if.ram_we, 32'd1);
        check("wr_last_addr", bus_if.ram_addr, 32'd13);
        check("wr_last_data", bus_if.ram_wdata, 32'hA3);
        check("wr_busy_idle", bus_if.idle, 32'd0);
        cyc();
        #3;
        check("wr_done_we", bus_if.ram_we, 32'd0);
        check("wr_addr_hold", bus_if.ram_addr, 32'd13);
        check("wr_done_idle", bus_if.idle, 32'd1);
        cyc();

        // Five writes under VGA: fifth dropped, overflow set then cleared
        w0 = wr_cnt;
        bus_if.vga_req  = 1'b1;
        bus_if.vga_addr = 19'd0;
        for (int j = 0; j < 5; j++) begin
            bus_if.cop_wr_en   = 1'b1;
            bus_if.cop_wr_addr = 19'(30 + j);
            bus_if.cop_wr_data = 8'(8'h30 + j);
            #3;
            check("ovf_we_blocked", bus_if.ram_we, 32'd0);
            check("ovf_full", bus_if.cop_wr_full, (j == 4) ? 32'd1 : 32'd0);
            check("ovf_pre", bus_if.overflow, 32'd0);
            cyc();
        end
        bus_if.cop_wr_en   = 1'b0;
        bus_if.clear_flags = 1'b1;
        #3;
        check("ovf_set", bus_if.overflow, 32'd1);
        check("ovf_full_hold", bus_if.cop_wr_full, 32'd1);
        cyc();
        bus_if.clear_flags = 1'b0;
        bus_if.vga_req     = 1'b0;
        #3;
        check("ovf_cleared", bus_if.overflow, 32'd0);
`ifdef FRAME_RAM_ARB_STALL_CNT_EN
        check("stall_cleared", stall_cnt, 32'd0);
`endif
        check("ovf_drain_we", bus_if.ram_we, 32'd1);
        check("ovf_drain_addr0", bus_if.ram_addr, 32'd30);
        check("ovf_drain_data0", bus_if.ram_wdata, 32'h30);
        cyc();
        for (int m = 1; m < 4; m++) begin
            #3;
            check("ovf_drain_we", bus_if.ram_we, 32'd1);
            check("ovf_drain_addr", bus_if.ram_addr, 32'(30 + m));
            if (m == 1) begin
                check("ovf_full_off", bus_if.cop_wr_full, 32'd0);
            end
            cyc();
        end
        #3;
        check("ovf_drain_end", bus_if.ram_we, 32'd0);
        check("ovf_idle", bus_if.idle, 32'd1);
        check("ovf_write_count", 32'(wr_cnt - w0), 32'd4);
        cyc();

        // Read-after-write to the same address
        bus_if.cop_wr_en   = 1'b1;
        bus_if.cop_wr_addr = 19'd20;
        bus_if.cop_wr_data = 8'h55;
        bus_if.cop_rd_req  = 1'b1;
        bus_if.cop_rd_addr = 19'd20;
        #3;
        check("raw_gnt0", bus_if.cop_rd_gnt, 32'd0);
        check("raw_we0", bus_if.ram_we, 32'd0);
        cyc();
        bus_if.cop_wr_en = 1'b0;
        #3;
        check("raw_we1", bus_if.ram_we, 32'd1);
        check("raw_addr1", bus_if.ram_addr, 32'd20);
        check("raw_gnt1", bus_if.cop_rd_gnt, 32'd0);
        cyc();
        #3;
        check("raw_gnt2", bus_if.cop_rd_gnt, 32'd1);
        check("raw_we2", bus_if.ram_we, 32'd0);
        check("raw_addr2", bus_if.ram_addr, 32'd20);
        cyc();
        bus_if.cop_rd_req = 1'b0;
        #3;
        check("raw_valid", bus_if.cop_rd_valid, 32'd1);
        check("raw_data", bus_if.cop_rd_data, 32'h55);
        cyc();

        // Reset with two entries buffered
        w0 = wr_cnt;
        bus_if.vga_req     = 1'b1;
        bus_if.cop_wr_en   = 1'b1;
        bus_if.cop_wr_addr = 19'd40;
        bus_if.cop_wr_data = 8'h40;
        cyc();
        bus_if.cop_wr_addr = 19'd41;
        bus_if.cop_wr_data = 8'h41;
        cyc();
        bus_if.cop_wr_en = 1'b0;
        bus_if.vga_req   = 1'b0;
        rst = 1'b1;
        #3;
        check("rst_mid_we", bus_if.ram_we, 32'd0);
        cyc();
        rst = 1'b0;
        #3;
        check("rst_mid_idle", bus_if.idle, 32'd1);
        check("rst_mid_full", bus_if.cop_wr_full, 32'd0);
        check("rst_mid_we_after", bus_if.ram_we, 32'd0);
`ifdef FRAME_RAM_ARB_STALL_CNT_EN
        check("rst_mid_stall", stall_cnt, 32'd0);
`endif
        cyc();
        #3;
        check("rst_mid_we_later", bus_if.ram_we, 32'd0);
        check("rst_mid_no_writes", 32'(wr_cnt - w0), 32'd0);
        cyc();

        // Reset landing on a granted read
        bus_if.cop_rd_req  = 1'b1;
        bus_if.cop_rd_addr = 19'd5;
        #3;
        check("rst_rd_gnt", bus_if.cop_rd_gnt, 32'd1);
        #1;
        rst = 1'b1;
        cyc();
        bus_if.cop_rd_req = 1'b0;
        #3;
        check("rst_rd_no_valid", bus_if.cop_rd_valid, 32'd0);
        rst = 1'b0;
        cyc();
        #3;
        check("rst_rd_no_valid_after", bus_if.cop_rd_valid, 32'd0);
        check("rst_rd_idle", bus_if.idle, 32'd1);
        check("rst_rd_vga_rvalid", bus_if.vga_rvalid, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
